// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Used by pipe_stall_ctrl and load_use_detect.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } pipe_state_e;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         MDU_LAT_DEFAULT = 32;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator: a load in EX whose destination
// is a source of the instruction in ID. Register $zero never creates a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ID_EX_MemtoReg,
    input  logic [4:0] ID_EX_Rt,
    input  logic [4:0] IF_ID_Rs,
    input  logic [4:0] IF_ID_Rt,
    output logic       load_use
);

    assign load_use = ID_EX_MemtoReg && (ID_EX_Rt != REG_ZERO) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: load-use interlock, branch flush, MDU hold,
// saturating stall counter. Define PIPE_MDU_STALL_EN to enable the MDU hold.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEFAULT,
    parameter int CNT_W   = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemtoReg,
    input  logic [4:0]       ID_EX_Rt,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             branch_taken,
    input  logic             mdu_start,
    output logic             PCWr,
    output logic             IF_IDWr,
    output logic             ID_EXMux,
    output logic             IF_IDFlush,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    logic        load_use;
    pipe_state_e state, next_state;

    load_use_detect u_load_use_detect (
        .ID_EX_MemtoReg (ID_EX_MemtoReg),
        .ID_EX_Rt       (ID_EX_Rt),
        .IF_ID_Rs       (IF_ID_Rs),
        .IF_ID_Rt       (IF_ID_Rt),
        .load_use       (load_use)
    );

`ifdef PIPE_MDU_STALL_EN
    // The RUN cycle that sees mdu_start is the first stall, so the wait
    // counts down from MDU_LAT-2 through 0.
    localparam int              MC_W     = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam logic [MC_W-1:0] MDU_LOAD = MC_W'(MDU_LAT - 2);

    logic [MC_W-1:0] mdu_cnt, mdu_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_cnt <= '0;
        end else begin
            mdu_cnt <= mdu_cnt_next;
        end
    end
`else
    logic unused_mdu;
    assign unused_mdu = mdu_start | (MDU_LAT < 2);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        PCWr       = 1'b1;
        IF_IDWr    = 1'b1;
        ID_EXMux   = 1'b1;
        IF_IDFlush = 1'b0;
        mdu_busy   = 1'b0;
`ifdef PIPE_MDU_STALL_EN
        mdu_cnt_next = mdu_cnt;
`endif
        if (!rst) begin
            case (state)
                RUN: begin
`ifdef PIPE_MDU_STALL_EN
                    if (mdu_start) begin
                        PCWr         = 1'b0;
                        IF_IDWr      = 1'b0;
                        ID_EXMux     = 1'b0;
                        mdu_cnt_next = MDU_LOAD;
                        next_state   = MDU_WAIT;
                    end else
`endif
                    if (load_use) begin
                        PCWr     = 1'b0;
                        IF_IDWr  = 1'b0;
                        ID_EXMux = 1'b0;
                    end else if (branch_taken) begin
                        IF_IDFlush = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    PCWr     = 1'b0;
                    IF_IDWr  = 1'b0;
                    ID_EXMux = 1'b0;
`ifdef PIPE_MDU_STALL_EN
                    mdu_busy = 1'b1;
                    if (mdu_cnt == '0) begin
                        next_state = RUN;
                    end else begin
                        mdu_cnt_next = mdu_cnt - 1'b1;
                    end
`else
                    next_state = RUN;
`endif
                end
                default: next_state = RUN;
            endcase
        end
    end

    // Saturates at all-ones so a long debug run never wraps back to small values.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!PCWr && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central pipeline sequencing controller for the 5-stage MIPS pipeline. Combines load-use interlock, taken-branch IF/ID flush and a multi-cycle multiply/divide (MDU) hold into one registered FSM. Drives the PC write enable, IF/ID write enable, IF/ID flush and ID/EX bubble mux. Keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- MDU_LAT, 32: total front-end stall cycles per MDU operation; legal range ≥2
- CNT_W, 16: width of the stall-cycle counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- ID_EX_MemtoReg  in  1  the instruction in EX is a load
- ID_EX_Rt  in  5  destination register of the load in EX
- IF_ID_Rs, IF_ID_Rt  in  5 each  source registers of the instruction in ID
- branch_taken  in  1  branch resolved taken in ID this cycle
- mdu_start  in  1  a mult/div is in EX this cycle (single-cycle pulse per op)
- PCWr  out  1  PC write enable
- IF_IDWr  out  1  IF/ID write enable
- ID_EXMux  out  1  1 = pass control, 0 = inject bubble into ID/EX
- IF_IDFlush  out  1  zero IF/ID on next edge
- mdu_busy  out  1  FSM in MDU_WAIT
- stall_cycles  out  CNT_W  cycles with PCWr=0 since reset

## Operation
- States: RUN, MDU_WAIT. Reset state RUN.
- load_use = ID_EX_MemtoReg && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || ID_EX_Rt==IF_ID_Rt).
- RUN, load_use: PCWr=0, IF_IDWr=0, ID_EXMux=0, IF_IDFlush=0; stay RUN (hazard clears after the bubble reaches EX).
- RUN, mdu_start (evaluated regardless of load_use): PCWr=0, IF_IDWr=0, ID_EXMux=0; load down-counter with MDU_LAT-2; next state MDU_WAIT.
- RUN, branch_taken with no load_use and no mdu_start: PCWr=1, IF_IDWr=1, ID_EXMux=1, IF_IDFlush=1.
- RUN otherwise: PCWr=IF_IDWr=ID_EXMux=1, IF_IDFlush=0.
- Priority on simultaneous events: mdu_start > load_use > branch_taken. A suppressed branch is not lost; IF/ID holds so it re-resolves next cycle.
- MDU_WAIT: PCWr=0, IF_IDWr=0, ID_EXMux=0, IF_IDFlush=0, mdu_busy=1; branch_taken, load_use and mdu_start ignored. Counter decrements each cycle; when counter==0, next state RUN.
- stall_cycles increments on every edge where PCWr==0; holds at all-ones (saturating, no wrap).

## Timing
- Control outputs are combinational from the current state and inputs; state, counter and stall_cycles are registered.
- Load-use: exactly 1 stall cycle per hazard.
- MDU: PCWr low for exactly MDU_LAT consecutive cycles (1 in RUN + MDU_LAT-1 in MDU_WAIT); RUN behaviour resumes on the cycle after the last MDU_WAIT cycle.
- rst=1: outputs forced to PCWr=1, IF_IDWr=1, ID_EXMux=1, IF_IDFlush=0, mdu_busy=0. On the edge: state←RUN, counter←0, stall_cycles←0. Reset mid-MDU_WAIT aborts the wait with no residual stall.

## Configuration
- PIPE_MDU_STALL_EN defined: MDU_WAIT state, down-counter and mdu_busy logic are present as above.
- Undefined: mdu_start is ignored, FSM never leaves RUN, and mdu_busy ties to 0. The port list stays unchanged.

## Structure
- Shared package pipe_ctrl_pkg: state enum (RUN, MDU_WAIT), REG_ZERO constant (5'd0), default MDU_LAT.
- One sub-module: load_use_detect (purely combinational comparator producing load_use). The FSM, counter and stall counter stay in the top.

## Test plan
- ID_EX_MemtoReg=1, ID_EX_Rt=5, IF_ID_Rs=5 → one cycle with PCWr=IF_IDWr=ID_EXMux=0; stall_cycles 0→1.
- Same case with ID_EX_Rt=0, IF_ID_Rs=0 → no stall; all enables 1.
- branch_taken=1 with no hazard → IF_IDFlush=1 and PCWr=1 for that cycle. branch_taken plus load_use → flush 0, stall 1 cycle, then flush 1 on the next cycle.
- MDU_LAT=32, mdu_start pulse → PCWr low exactly 32 cycles; mdu_busy high 31 cycles; stall_cycles=32; branch_taken during the wait produces no flush.
- rst asserted at cycle 10 of an MDU wait → next cycle state RUN, PCWr=1, stall_cycles=0.
- CNT_W=4, force 20 stall cycles → stall_cycles holds at 15.
